bit_slice_collector: RTL and testbench
======================================

Name: bit_slice_collector

Overview:
- Upstream neighbour of the valid-bits nonzero test in the CGRA PE datapath.
- Collects narrow bit slices arriving LSB-first on an inter-PE link and assembles them into a DATA_SIZE word.
- Tracks the count of valid bits and presents word, valid-bit count and exclude-LSB flag to the nonzero-test stage.
- Holds the completed word until the consumer acknowledges it.

Parameters:
- DATA_SIZE, 8, assembled word width; must be an integer multiple of SLICE_SIZE.
- SLICE_SIZE, 2, bits accepted per beat; legal values 1, 2, 4.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- in_valid  input  1  slice present.
- in_ready  output  1  collector can accept a slice.
- in_slice  input  SLICE_SIZE  next slice, LSB-first.
- in_last  input  1  qualifies in_valid; this slice closes the word early.
- exclude_lsb_cfg  input  1  PE config bit; sampled on the first beat of each word.
- out_word  output  DATA_SIZE  assembled word; unwritten bits read 0.
- out_valid_bits  output  3  valid-bit count, saturating at 7.
- out_exclude_lsb  output  1  latched exclude_lsb_cfg for the current word.
- out_done  output  1  word complete and held.
- out_ack  input  1  consumer takes the word.

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs, including mid-word or in HOLD):
  - state=EMPTY; word=0; count=0.
  - out_valid_bits=0, out_exclude_lsb=0, out_done=0, in_ready=1.
- States:
  - EMPTY: no beats collected.
  - FILL: 0 < count < DATA_SIZE, word not closed.
  - HOLD: word closed.
- in_ready is 1 in EMPTY and FILL, 0 in HOLD. It is registered state only, with no combinational path from out_ack.
- Beat accepted when in_valid & in_ready:
  - word[count +: SLICE_SIZE] <= in_slice; count <= count + SLICE_SIZE.
  - On the first beat (EMPTY), out_exclude_lsb <= exclude_lsb_cfg.
  - Next state is HOLD if the new count equals DATA_SIZE or in_last=1; otherwise FILL.
- Latency: beat accepted in cycle t is visible on out_word, out_valid_bits and out_done in cycle t+1.
- out_valid_bits = min(count, 7). For a full 8-bit word it reads 7, which matches the 3-bit mask convention of the downstream stage.
- out_done = (state==HOLD). It is never asserted in EMPTY or FILL.
- HOLD exit: out_ack=1 returns the block to EMPTY next cycle and clears word, count, out_valid_bits and out_exclude_lsb.
- out_ack while not in HOLD is ignored.
- out_ack with in_valid in the same HOLD cycle: the beat is not accepted (in_ready=0). It is accepted the following cycle as the first beat of the next word, giving one bubble per word.
- in_valid=0 holds all state. in_last without in_valid has no effect.
- out_word changes only on accepted beats, ack or reset.

Optional Feature:
- Macro: BIT_SLICE_EARLY_NZ_EN.
- Defined:
  - Adds output out_nz_early (1 bit) and a sticky register nz, cleared on reset, on ack, and at the start of each word.
  - On each accepted beat: nz <= nz | (in_slice masked != 0). On the first beat with out_exclude_lsb=1, bit 0 of the slice is masked.
  - out_nz_early = nz, registered, same t+1 latency. It lets the downstream stage resolve a predicate before the word completes.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds DATA_SIZE (the existing global data-width define), SLICE_SIZE default, the 3-bit valid-bit-count width and the state encoding (EMPTY=0, FILL=1, HOLD=2).
- No sub-module. Count saturation and slice write-enable decode stay inline.

Test Plan (DATA_SIZE=8, SLICE_SIZE=2):
- Beats 01,00,10,11, no in_last -> after 4th beat: out_word=0xE1, out_valid_bits=7, out_done=1, in_ready=0.
- Beats 10 then 01 with in_last -> out_word=0x06, out_valid_bits=4, out_done=1. Ack -> next cycle out_word=0, out_done=0, in_ready=1.
- In HOLD, out_ack=1 with in_valid=1, in_slice=11 -> slice not taken that cycle; taken next cycle; out_word=0x03, out_valid_bits=2.
- Reset asserted after 2 beats -> next cycle out_word=0, out_valid_bits=0, in_ready=1. Stray out_ack in EMPTY -> no change.
- BIT_SLICE_EARLY_NZ_EN, exclude_lsb_cfg=1, beats 01,00,10 -> out_nz_early reads 0,0,1 after each beat.
- exclude_lsb_cfg toggled mid-word -> out_exclude_lsb keeps the first-beat value until ack.

Source files
------------

// File: rtl/bit_slice_collector_pkg.sv
// bit_slice_collector_pkg
// Shared definitions for the bit-slice collector:
//   - default assembled-word width (the datapath-wide data width) and slice width
//   - width of the saturating valid-bit count presented downstream
//   - collector state encoding (EMPTY=0, FILL=1, HOLD=2)
//   - helper that saturates a bit count into the 3-bit valid-bit field
package bit_slice_collector_pkg;

  localparam int DEFAULT_DATA_SIZE  = 8;
  localparam int DEFAULT_SLICE_SIZE = 2;
  localparam int VALID_BITS_W       = 3;
  localparam int VALID_BITS_MAX     = (1 << VALID_BITS_W) - 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // The downstream nonzero test uses a 3-bit mask, so a full 8-bit word
  // reports 7 rather than wrapping to 0.
  function automatic logic [VALID_BITS_W-1:0] satValidBits(input int unsigned bitCount);
    if (bitCount > VALID_BITS_MAX) begin
      return VALID_BITS_W'(VALID_BITS_MAX);
    end
    return VALID_BITS_W'(bitCount);
  endfunction

endpackage

// File: rtl/bit_slice_collector.sv
// bit_slice_collector
// Assembles LSB-first bit slices from an inter-PE link into a DATA_SIZE word
// and holds it for the valid-bits nonzero-test stage until acknowledged.
//
// Handshake: a slice is accepted on a rising edge where in_valid && in_ready.
// in_ready is a pure decode of registered state (1 in EMPTY/FILL, 0 in HOLD);
// it has no combinational dependence on out_ack, so the cycle that acks a
// held word never accepts a slice (one bubble per word).
//
// Optional feature macro: BIT_SLICE_EARLY_NZ_EN
//   When defined, adds out_nz_early, a sticky "any masked slice bit set"
//   flag for the word being collected, with the same t+1 latency as out_word.
//
// Parameters:
//   DATA_SIZE  - assembled word width, integer multiple of SLICE_SIZE
//   SLICE_SIZE - bits per beat (1, 2 or 4)
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready - slice handshake
//   in_slice, in_last - slice data and early word close
//   exclude_lsb_cfg   - PE config bit, latched on each word's first beat
//   out_word          - assembled word, unwritten bits read 0
//   out_valid_bits    - valid-bit count saturating at 7
//   out_exclude_lsb   - latched exclude_lsb_cfg for the current word
//   out_done          - word closed and held
//   out_ack           - consumer takes the held word
//   out_nz_early      - (macro only) sticky nonzero flag for the current word
//   dbgState          - current collector state, for observation only
module bit_slice_collector
  import bit_slice_collector_pkg::*;
#(
  parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
  parameter int SLICE_SIZE = DEFAULT_SLICE_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLICE_SIZE-1:0]   in_slice,
  input  logic                    in_last,
  input  logic                    exclude_lsb_cfg,
  output logic [DATA_SIZE-1:0]    out_word,
  output logic [VALID_BITS_W-1:0] out_valid_bits,
  output logic                    out_exclude_lsb,
  output logic                    out_done,
  input  logic                    out_ack,
`ifdef BIT_SLICE_EARLY_NZ_EN
  output logic                    out_nz_early,
`endif
  output state_t                  dbgState
);

  localparam int NUM_SLICES = DATA_SIZE / SLICE_SIZE;
  // Count must be able to hold DATA_SIZE itself (the "full" value).
  localparam int CNT_W      = $clog2(DATA_SIZE + 1);

  state_t             state;
  state_t             nextState;
  logic [DATA_SIZE-1:0] word;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   newCount;
  logic               excludeLsb;
  logic               beatFire;
  logic               ackFire;

  always_comb begin
    nextState = state;
    beatFire  = in_valid && (state != HOLD);
    ackFire   = out_ack && (state == HOLD);
    newCount  = count + CNT_W'(SLICE_SIZE);
    case (state)
      EMPTY, FILL: begin
        if (beatFire) begin
          nextState = ((newCount == CNT_W'(DATA_SIZE)) || in_last) ? HOLD : FILL;
        end
      end
      HOLD: begin
        if (out_ack) begin
          nextState = EMPTY;
        end
      end
      default: nextState = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ackFire) begin
      word       <= '0;
      count      <= '0;
      excludeLsb <= 1'b0;
    end else if (beatFire) begin
      // Slot write-enable decode: the slot whose base equals the current count.
      for (int i = 0; i < NUM_SLICES; i++) begin
        if (count == CNT_W'(i * SLICE_SIZE)) begin
          word[i*SLICE_SIZE +: SLICE_SIZE] <= in_slice;
        end
      end
      count <= newCount;
      if (state == EMPTY) begin
        excludeLsb <= exclude_lsb_cfg;
      end
    end
  end

`ifdef BIT_SLICE_EARLY_NZ_EN
  logic                  nz;
  logic [SLICE_SIZE-1:0] lsbMask;
  logic                  nzNext;

  // On the first beat the flag being latched (exclude_lsb_cfg) governs the
  // mask, and the sticky value restarts from zero for the new word.
  always_comb begin
    lsbMask    = '0;
    lsbMask[0] = (state == EMPTY) && exclude_lsb_cfg;
    nzNext     = ((state == EMPTY) ? 1'b0 : nz) || (|(in_slice & ~lsbMask));
  end

  always_ff @(posedge clk) begin
    if (reset || ackFire) begin
      nz <= 1'b0;
    end else if (beatFire) begin
      nz <= nzNext;
    end
  end

  assign out_nz_early = nz;
`endif

  assign in_ready        = (state != HOLD);
  assign out_done        = (state == HOLD);
  assign out_word        = word;
  assign out_valid_bits  = satValidBits(32'(count));
  assign out_exclude_lsb = excludeLsb;
  assign dbgState        = state;

endmodule

// File: tb/tb_bit_slice_collector.sv
// tb_bit_slice_collector
// Directed scenarios with literal expectations, then randomized traffic,
// all continuously compared against a behavioural model of the collector.
module tb_bit_slice_collector;
  import bit_slice_collector_pkg::*;

  localparam int DW = 8;
  localparam int SW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_slice = '0;
  logic          in_last = 1'b0;
  logic          exclude_lsb_cfg = 1'b0;
  logic [DW-1:0] out_word;
  logic [2:0]    out_valid_bits;
  logic          out_exclude_lsb;
  logic          out_done;
  logic          out_ack = 1'b0;
`ifdef BIT_SLICE_EARLY_NZ_EN
  logic          out_nz_early;
`endif
  state_t        dbgState;

  bit_slice_collector #(.DATA_SIZE(DW), .SLICE_SIZE(SW)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_slice        (in_slice),
    .in_last         (in_last),
    .exclude_lsb_cfg (exclude_lsb_cfg),
    .out_word        (out_word),
    .out_valid_bits  (out_valid_bits),
    .out_exclude_lsb (out_exclude_lsb),
    .out_done        (out_done),
    .out_ack         (out_ack),
`ifdef BIT_SLICE_EARLY_NZ_EN
    .out_nz_early    (out_nz_early),
`endif
    .dbgState        (dbgState)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The word is a bit count plus an integer accumulator; a word closes when
  // it is full or in_last arrives, and waits for an ack.
  int m_word = 0;
  int m_cnt  = 0;
  bit m_hold = 0;
  bit m_excl = 0;
  bit m_nz   = 0;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) begin
    int masked;
    if (reset) begin
      m_word = 0; m_cnt = 0; m_hold = 0; m_excl = 0; m_nz = 0;
    end else if (m_hold) begin
      if (out_ack) begin
        m_word = 0; m_cnt = 0; m_hold = 0; m_excl = 0; m_nz = 0;
      end
    end else if (in_valid) begin
      masked = int'(in_slice);
      if (m_cnt == 0) begin
        m_excl = exclude_lsb_cfg;
        m_nz   = 0;
        if (exclude_lsb_cfg) masked = masked & ~1;
      end
      if (masked != 0) m_nz = 1;
      m_word = m_word + int'(in_slice) * (1 << m_cnt);
      m_cnt  = m_cnt + SW;
      if (m_cnt == DW || in_last) begin
        m_hold = 1;
        exp_q.push_back(DW'(m_word));
      end
    end
  end

  // ---------------- compare process ----------------
  bit check_en  = 0;
  bit prev_done = 0;

  always @(negedge clk) begin
    if (check_en) begin
      check("word",        32'(out_word),        32'(m_word));
      check("valid_bits",  32'(out_valid_bits),  32'((m_cnt > 7) ? 7 : m_cnt));
      check("done",        32'(out_done),        32'(m_hold));
      check("ready",       32'(in_ready),        32'(!m_hold));
      check("exclude_lsb", 32'(out_exclude_lsb), 32'(m_excl));
      check("state",       32'(dbgState),        m_hold ? 32'd2 : (m_cnt == 0 ? 32'd0 : 32'd1));
`ifdef BIT_SLICE_EARLY_NZ_EN
      check("nz_early",    32'(out_nz_early),    32'(m_nz));
`endif
      if (out_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("sb_word_present", 32'd0, 32'd1);
        end else begin
          check("sb_word", 32'(out_word), 32'(exp_q.pop_front()));
        end
      end
      prev_done = out_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic beat(input logic [SW-1:0] s, input logic last, input logic cfg);
    in_valid        = 1'b1;
    in_slice        = s;
    in_last         = last;
    exclude_lsb_cfg = cfg;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_ack();
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    @(posedge clk); #1;
    check_en = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("lit_reset_word",  32'(out_word),       32'h0);
    check("lit_reset_vb",    32'(out_valid_bits), 32'h0);
    check("lit_reset_done",  32'(out_done),       32'h0);
    check("lit_reset_ready", 32'(in_ready),       32'h1);

    // Full word from four beats.
    beat(2'b01, 0, 0); beat(2'b00, 0, 0); beat(2'b10, 0, 0); beat(2'b11, 0, 0);
    @(negedge clk);
    check("lit_full_word",  32'(out_word),       32'hE1);
    check("lit_full_vb",    32'(out_valid_bits), 32'd7);
    check("lit_full_done",  32'(out_done),       32'h1);
    check("lit_full_ready", 32'(in_ready),       32'h0);
    do_ack();
    @(negedge clk);
    check("lit_ack_word",  32'(out_word), 32'h0);
    check("lit_ack_ready", 32'(in_ready), 32'h1);

    // Early close; cfg changes mid-word but the latched flag must not.
    beat(2'b10, 0, 1); beat(2'b01, 1, 0);
    @(negedge clk);
    check("lit_last_word", 32'(out_word),        32'h06);
    check("lit_last_vb",   32'(out_valid_bits),  32'd4);
    check("lit_last_done", 32'(out_done),        32'h1);
    check("lit_last_excl", 32'(out_exclude_lsb), 32'h1);
    do_ack();
    @(negedge clk);
    check("lit_ack2_word", 32'(out_word),        32'h0);
    check("lit_ack2_done", 32'(out_done),        32'h0);
    check("lit_ack2_excl", 32'(out_exclude_lsb), 32'h0);

    // Ack and a new slice in the same HOLD cycle: slice waits one cycle.
    beat(2'b00, 1, 0);
    out_ack = 1'b1; in_valid = 1'b1; in_slice = 2'b11;
    @(posedge clk); #1;
    out_ack = 1'b0;
    @(negedge clk);
    check("lit_bubble_word",  32'(out_word), 32'h0);
    check("lit_bubble_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lit_after_bubble_word", 32'(out_word),       32'h03);
    check("lit_after_bubble_vb",   32'(out_valid_bits), 32'd2);

    // Reset mid-word wins over a concurrent beat.
    beat(2'b01, 0, 0);
    reset = 1'b1; in_valid = 1'b1; in_slice = 2'b11;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("lit_midreset_word",  32'(out_word),       32'h0);
    check("lit_midreset_vb",    32'(out_valid_bits), 32'h0);
    check("lit_midreset_ready", 32'(in_ready),       32'h1);
    do_ack();
    @(negedge clk);
    check("lit_stray_ack_word", 32'(out_word), 32'h0);
    check("lit_stray_ack_done", 32'(out_done), 32'h0);

    // Exclude-LSB masking of the first beat.
    beat(2'b01, 0, 1);
    @(negedge clk);
`ifdef BIT_SLICE_EARLY_NZ_EN
    check("lit_nz_beat1", 32'(out_nz_early), 32'h0);
`endif
    beat(2'b00, 0, 0);
    @(negedge clk);
`ifdef BIT_SLICE_EARLY_NZ_EN
    check("lit_nz_beat2", 32'(out_nz_early), 32'h0);
`endif
    beat(2'b10, 0, 0);
    @(negedge clk);
`ifdef BIT_SLICE_EARLY_NZ_EN
    check("lit_nz_beat3", 32'(out_nz_early), 32'h1);
`endif
    beat(2'b00, 0, 0);
    @(negedge clk);
    check("lit_nz_word", 32'(out_word),        32'h21);
    check("lit_nz_excl", 32'(out_exclude_lsb), 32'h1);
    do_ack();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid        = ($urandom_range(0, 3) != 0);
      in_slice        = SW'($urandom_range(0, 3));
      in_last         = ($urandom_range(0, 5) == 0);
      exclude_lsb_cfg = ($urandom_range(0, 1) == 1);
      out_ack         = ($urandom_range(0, 2) == 0);
      reset           = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ack = 1'b0; reset = 1'b0; in_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sb_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
